// File: rtl/bsg_gateway_run_ctrl_pkg.sv
// Shared types for the gateway run sequencer: FSM states, failure codes and
// a width helper that never returns zero.
package bsg_gateway_run_ctrl_pkg;

    localparam int fail_code_width_gp = 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CALIB,
        SETTLE,
        ENABLE,
        RUN,
        DONE
    } state_e;

    typedef enum logic [fail_code_width_gp-1:0] {
        e_fail_none,
        e_fail_node,
        e_fail_timeout,
        e_fail_calib
    } fail_code_e;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_gateway_run_ctrl_timer.sv
// Clear/enable up-counter with a terminal-count compare.
// It saturates at all-ones instead of wrapping.
module bsg_gateway_run_ctrl_timer #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               en_i,
    input  logic [width_p-1:0] limit_i,
    output logic [width_p-1:0] count_o,
    output logic               tc_o
);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            count_o <= '0;
        else if (clear_i)
            count_o <= '0;
        else if (en_i && (count_o != {width_p{1'b1}}))
            count_o <= count_o + width_p'(1);
    end

    assign tc_o = (count_o == limit_i);

endmodule

// File: rtl/bsg_gateway_run_ctrl.sv
// Gateway comm-link bring-up sequencer: calib wait, settle, staggered node
// enables, then a watched run that ends in a sticky pass/fail verdict.
module bsg_gateway_run_ctrl
    import bsg_gateway_run_ctrl_pkg::*;
#(
    parameter int nodes_p          = 1,
    parameter int settle_cycles_p  = 64,
    parameter int stagger_cycles_p = 16,
    parameter int timeout_cycles_p = 1 << 20,
    parameter int ctr_width_p      = 32
) (
    input  logic                             core_clk_i,
    input  logic                             async_reset_n_i,
    input  logic                             start_i,
    input  logic                             core_calib_reset_i,
    input  logic [nodes_p-1:0]               node_done_i,
    input  logic [nodes_p-1:0]               node_error_i,
    output logic [nodes_p-1:0]               node_enable_o,
    output logic                             run_active_o,
    output logic                             pass_o,
    output logic                             fail_o,
    output logic [fail_code_width_gp-1:0]    fail_code_o,
    output logic [safe_clog2(nodes_p)-1:0]   fail_node_o,
    output logic [ctr_width_p-1:0]           elapsed_o
);

    localparam int node_width_lp = safe_clog2(nodes_p);

    state_e                   state_r, state_n;
    logic [nodes_p-1:0]       enable_r, enable_n, next_enable;
    logic [nodes_p-1:0]       done_seen_r, done_seen_n;
    logic                     pass_r, pass_n, fail_r, fail_n;
    fail_code_e               code_r, code_n;
    logic [node_width_lp-1:0] node_r, node_n, err_idx;
    logic                     run_active_r;

    logic                     step_clear, step_en, step_tc, settle_done;
    logic [ctr_width_p-1:0]   step_count;
    logic                     run_clear, run_en, run_tc;
    logic [ctr_width_p-1:0]   run_count;

    // One counter paces both the settle window and the enable stagger.
    bsg_gateway_run_ctrl_timer #(.width_p(ctr_width_p)) step_timer (
        .clk_i     (core_clk_i),
        .reset_n_i (async_reset_n_i),
        .clear_i   (step_clear),
        .en_i      (step_en),
        .limit_i   (ctr_width_p'(stagger_cycles_p - 1)),
        .count_o   (step_count),
        .tc_o      (step_tc)
    );

    bsg_gateway_run_ctrl_timer #(.width_p(ctr_width_p)) run_timer (
        .clk_i     (core_clk_i),
        .reset_n_i (async_reset_n_i),
        .clear_i   (run_clear),
        .en_i      (run_en),
        .limit_i   (ctr_width_p'(timeout_cycles_p - 1)),
        .count_o   (run_count),
        .tc_o      (run_tc)
    );

    assign settle_done = (step_count == ctr_width_p'(settle_cycles_p - 1));
    assign next_enable = (enable_r << 1) | nodes_p'(1);

    always_comb begin
        err_idx = '0;
        for (int k = nodes_p - 1; k >= 0; k--)
            if (node_error_i[k])
                err_idx = node_width_lp'(k);
    end

    always_comb begin
        state_n     = state_r;
        enable_n    = enable_r;
        done_seen_n = done_seen_r;
        pass_n      = pass_r;
        fail_n      = fail_r;
        code_n      = code_r;
        node_n      = node_r;
        step_clear  = 1'b0;
        step_en     = 1'b0;
        run_clear   = 1'b0;
        run_en      = 1'b0;

        case (state_r)
            IDLE: begin
                if (start_i)
                    state_n = WAIT_CALIB;
            end
            WAIT_CALIB: begin
                if (!core_calib_reset_i) begin
                    state_n    = SETTLE;
                    step_clear = 1'b1;
                end
            end
            SETTLE: begin
                if (core_calib_reset_i) begin
                    state_n = DONE;
                    fail_n  = 1'b1;
                    code_n  = e_fail_calib;
                end else if (settle_done) begin
                    state_n    = ENABLE;
                    enable_n   = next_enable;
                    step_clear = 1'b1;
                end else begin
                    step_en = 1'b1;
                end
            end
            ENABLE: begin
                // Node errors are not trusted yet, but done is already collected.
                done_seen_n = done_seen_r | node_done_i;
                if (core_calib_reset_i) begin
                    state_n = DONE;
                    fail_n  = 1'b1;
                    code_n  = e_fail_calib;
                end else if (&enable_r) begin
                    state_n   = RUN;
                    run_clear = 1'b1;
                end else if (step_tc) begin
                    enable_n   = next_enable;
                    step_clear = 1'b1;
                end else begin
                    step_en = 1'b1;
                end
            end
            RUN: begin
                done_seen_n = done_seen_r | node_done_i;
                if (core_calib_reset_i) begin
                    state_n = DONE;
                    fail_n  = 1'b1;
                    code_n  = e_fail_calib;
                end else if (|node_error_i) begin
                    state_n = DONE;
                    fail_n  = 1'b1;
                    code_n  = e_fail_node;
                    node_n  = err_idx;
                end else if (&done_seen_r) begin
                    state_n = DONE;
                    pass_n  = 1'b1;
                end else if (run_tc) begin
                    state_n = DONE;
                    fail_n  = 1'b1;
                    code_n  = e_fail_timeout;
                end else begin
                    run_en = 1'b1;
                end
            end
            DONE: begin
                if (start_i) begin
                    state_n     = WAIT_CALIB;
                    pass_n      = 1'b0;
                    fail_n      = 1'b0;
                    code_n      = e_fail_none;
                    node_n      = '0;
                    done_seen_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase

        if (state_n == DONE)
            enable_n = '0;
    end

    always_ff @(posedge core_clk_i or negedge async_reset_n_i) begin
        if (!async_reset_n_i) begin
            state_r      <= IDLE;
            enable_r     <= '0;
            done_seen_r  <= '0;
            pass_r       <= 1'b0;
            fail_r       <= 1'b0;
            code_r       <= e_fail_none;
            node_r       <= '0;
            run_active_r <= 1'b0;
        end else begin
            state_r      <= state_n;
            enable_r     <= enable_n;
            done_seen_r  <= done_seen_n;
            pass_r       <= pass_n;
            fail_r       <= fail_n;
            code_r       <= code_n;
            node_r       <= node_n;
            run_active_r <= (state_n == SETTLE) || (state_n == ENABLE) || (state_n == RUN);
        end
    end

    assign node_enable_o = enable_r;
    assign run_active_o  = run_active_r;
    assign pass_o        = pass_r;
    assign fail_o        = fail_r;
    assign fail_code_o   = code_r;
    assign fail_node_o   = node_r;
    assign elapsed_o     = run_count;

endmodule

// File: tb/tb_bsg_gateway_run_ctrl.sv
// Self-checking bench for bsg_gateway_run_ctrl: expected waveforms are derived
// from the sequencing rules as cycle arithmetic relative to the start pulse.
module tb_bsg_gateway_run_ctrl;

    localparam int N       = 2;
    localparam int SETTLE  = 4;
    localparam int STAGGER = 2;
    localparam int TIMEOUT = 20;
    localparam int CW      = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          calib = 1'b0;
    logic [N-1:0]  node_done = '0;
    logic [N-1:0]  node_error = '0;
    logic [N-1:0]  enable;
    logic          run_active, pass, fail;
    logic [1:0]    fail_code;
    logic          fail_node;
    logic [CW-1:0] elapsed;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bsg_gateway_run_ctrl #(
        .nodes_p          (N),
        .settle_cycles_p  (SETTLE),
        .stagger_cycles_p (STAGGER),
        .timeout_cycles_p (TIMEOUT),
        .ctr_width_p      (CW)
    ) dut (
        .core_clk_i         (clk),
        .async_reset_n_i    (rst_n),
        .start_i            (start),
        .core_calib_reset_i (calib),
        .node_done_i        (node_done),
        .node_error_i       (node_error),
        .node_enable_o      (enable),
        .run_active_o       (run_active),
        .pass_o             (pass),
        .fail_o             (fail),
        .fail_code_o        (fail_code),
        .fail_node_o        (fail_node),
        .elapsed_o          (elapsed)
    );

    task automatic applyStimulus(input logic s, input logic cr, input logic [N-1:0] d, input logic [N-1:0] e);
        start      = s;
        calib      = cr;
        node_done  = d;
        node_error = e;
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, 1'b0, '0, '0);
        #1 rst_n = 1'b0;
        #2;
        vectors++;
        if ({enable, run_active, pass, fail, fail_code, fail_node} !== 8'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs got %b exp 0", {enable, run_active, pass, fail, fail_code, fail_node});
        end
        vectors++;
        if (elapsed !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_elapsed got %0d exp 0", elapsed);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({enable, run_active, pass, fail} !== 5'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_outputs got %b exp 0", {enable, run_active, pass, fail});
        end
    endtask

    // d: calib-high cycles after start; t0/t1: RUN cycle each done rises;
    // e/emask: RUN cycle and nodes of an error pulse (emask 0 means none).
    task automatic test_run(input string name, input int d, input int t0, input int t1,
                            input int e, input logic [N-1:0] emask);
        int l, r0, a, x, last, exp_el;
        logic [1:0] code;
        logic node, vdone, exp_act;
        logic [N-1:0] exp_en;
        l  = d + 1;
        r0 = l + SETTLE + (N - 1) * STAGGER + 2;
        a  = ((t0 > t1) ? t0 : t1) + 1;
        x  = TIMEOUT - 1;
        code = 2'd2;
        node = 1'b0;
        if (a <= x) begin
            x = a;
            code = 2'd0;
        end
        if (emask != '0 && e <= x) begin
            x = e;
            code = 2'd1;
            node = emask[0] ? 1'b0 : 1'b1;
        end
        last = r0 + x + 3;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            if (c > 0) begin
                vdone   = (c >= r0 + x + 1);
                exp_act = (c >= l + 1) && !vdone;
                for (int k = 0; k < N; k++)
                    exp_en[k] = (c >= l + SETTLE + k * STAGGER + 1) && !vdone;
                vectors++;
                if (enable !== exp_en) begin
                    miscompares++;
                    $display("[TB] FAIL %s enable c=%0d got %b exp %b", name, c, enable, exp_en);
                end
                vectors++;
                if (run_active !== exp_act) begin
                    miscompares++;
                    $display("[TB] FAIL %s run_active c=%0d got %b exp %b", name, c, run_active, exp_act);
                end
                vectors++;
                if ({pass, fail} !== {vdone && code == 2'd0, vdone && code != 2'd0}) begin
                    miscompares++;
                    $display("[TB] FAIL %s verdict c=%0d got pass=%b fail=%b exp code %0d done=%b",
                             name, c, pass, fail, code, vdone);
                end
                vectors++;
                if ({fail_code, fail_node} !== (vdone ? {code, node} : 3'b000)) begin
                    miscompares++;
                    $display("[TB] FAIL %s code c=%0d got %0d/%0d exp %0d/%0d",
                             name, c, fail_code, fail_node, vdone ? code : 2'd0, vdone ? node : 1'b0);
                end
                if (c >= r0) begin
                    exp_el = (c - r0 > x) ? x : c - r0;
                    vectors++;
                    if (elapsed !== CW'(exp_el)) begin
                        miscompares++;
                        $display("[TB] FAIL %s elapsed c=%0d got %0d exp %0d", name, c, elapsed, exp_el);
                    end
                end
            end
            applyStimulus(c == 0, (c >= 1 && c <= d),
                          {c >= r0 + t1, c >= r0 + t0},
                          (c == r0 + e) ? emask : ((c == l + 2 || c == r0 - 1) ? 2'b11 : 2'b00));
        end
    endtask

    task automatic test_calib_abort(input int d);
        int l, ca;
        logic vdone;
        l  = d + 1;
        ca = l + SETTLE + 1;
        for (int c = 0; c <= ca + 3; c++) begin
            @(negedge clk);
            if (c > 0) begin
                vdone = (c >= ca + 1);
                vectors++;
                if (enable !== {1'b0, (c >= l + SETTLE + 1) && !vdone}) begin
                    miscompares++;
                    $display("[TB] FAIL calib_abort enable c=%0d got %b", c, enable);
                end
                vectors++;
                if (run_active !== ((c >= l + 1) && !vdone)) begin
                    miscompares++;
                    $display("[TB] FAIL calib_abort run_active c=%0d got %b", c, run_active);
                end
                vectors++;
                if ({pass, fail, fail_code, fail_node} !== (vdone ? 5'b01110 : 5'b00000)) begin
                    miscompares++;
                    $display("[TB] FAIL calib_abort verdict c=%0d got %b exp %b",
                             c, {pass, fail, fail_code, fail_node}, vdone ? 5'b01110 : 5'b00000);
                end
            end
            applyStimulus(c == 0, (c >= 1 && c <= d) || (c >= ca), 2'b00, 2'b00);
        end
    endtask

    task automatic test_async_reset();
        int r0;
        r0 = 1 + SETTLE + (N - 1) * STAGGER + 2;
        for (int c = 0; c <= r0 + 1; c++) begin
            @(negedge clk);
            applyStimulus(c == 0 || c == r0 + 1, 1'b0, 2'b00, 2'b00);
        end
        @(negedge clk);
        vectors++;
        if ({run_active, enable, pass, fail} !== 5'b11100 || elapsed !== CW'(2)) begin
            miscompares++;
            $display("[TB] FAIL start_ignored got act/en/pass/fail=%b elapsed=%0d exp 11100 elapsed=2",
                     {run_active, enable, pass, fail}, elapsed);
        end
        applyStimulus(1'b0, 1'b0, 2'b00, 2'b00);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({enable, run_active, pass, fail, fail_code, fail_node} !== 8'b0 || elapsed !== '0) begin
            miscompares++;
            $display("[TB] FAIL async_reset got %b elapsed=%0d exp 0",
                     {enable, run_active, pass, fail, fail_code, fail_node}, elapsed);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({enable, run_active} !== 3'b0) begin
            miscompares++;
            $display("[TB] FAIL post_reset_idle got %b exp 0", {enable, run_active});
        end
    endtask

    task automatic test_random(input int runs);
        int d, t0, t1, e;
        logic [N-1:0] emask;
        for (int i = 0; i < runs; i++) begin
            d  = int'($urandom_range(0, 4));
            t0 = int'($urandom_range(0, 22));
            t1 = int'($urandom_range(0, 22));
            e  = int'($urandom_range(0, 21));
            emask = ($urandom_range(0, 2) == 0) ? 2'b00 : N'($urandom_range(1, 3));
            test_run("random", d, t0, t1, e, emask);
        end
    endtask

    initial begin
        test_reset();
        test_run("pass", 10, 5, 5, 0, 2'b00);
        test_run("node_error", 2, 30, 30, 3, 2'b10);
        test_run("error_vs_done", 1, 2, 4, 5, 2'b01);
        test_run("timeout", 0, 40, 40, 0, 2'b00);
        test_run("rerun_pass", 3, 1, 0, 0, 2'b00);
        test_run("error_vs_timeout", 0, 40, 40, 19, 2'b11);
        test_run("done_at_timeout", 0, 18, 10, 0, 2'b00);
        test_calib_abort(2);
        test_random(12);
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
